register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rs1_read_index  input  5  source register 1 address.
REQ-006 rs2_read_index  input  5  source register 2 address.
REQ-007 rs1_read_data  output  32  source register 1 value.
REQ-008 rs2_read_data  output  32  source register 2 value.
REQ-009 rd_write_index  input  5  destination register address from write-back.
REQ-010 rd_write_data  input  32  destination register data from write-back.
REQ-011 rd_write_enable  input  1  commit rd_write_data to rd_write_index this cycle.
REQ-012 pc_write_data  input  32  next PC from write-back.
REQ-013 pc_write_enable  input  1  load pc_write_data into PC this cycle.
REQ-014 pc_read_data  output  32  current PC.

Function
REQ-015 Storage SHALL be 31 registers of 32 bits for x1..x31; x0 SHALL have no storage.
REQ-016 On a rising edge with rd_write_enable=1 and rd_write_index!=0, the addressed register SHALL take rd_write_data; write latency is 1 cycle.
REQ-017 Writes with rd_write_index=0 SHALL be discarded; no register changes.
REQ-018 rd_write_enable=0 SHALL leave all registers unchanged, whatever index and data are.
REQ-019 Read ports SHALL be combinational, with zero-cycle latency from index to data.
REQ-020 A read of index 0 SHALL return 32'h0000_0000 under all conditions, including a concurrent write to index 0.
REQ-021 With BYPASS=1, a read index equal to a nonzero rd_write_index while rd_write_enable=1 SHALL return rd_write_data in the same cycle.
REQ-022 With BYPASS=0, the read in REQ-021 SHALL return the pre-edge stored value; the new value becomes visible the following cycle.
REQ-023 Both read ports SHALL be independent; the same index on both ports SHALL return identical data, and bypass SHALL apply to each port separately.
REQ-024 The PC register SHALL load pc_write_data on a rising edge when pc_write_enable=1 and hold otherwise.
REQ-025 pc_read_data SHALL be the registered PC with no bypass; it shows the new value one cycle after the write.
REQ-026 The PC SHALL store all 32 bits unmodified; alignment checking is not this block's job.
REQ-027 A register write and a PC write in the same cycle SHALL both complete.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, clear x1..x31 to 0 and set PC to RESET_PC.
REQ-029 While rst=1, writes SHALL be ignored; rs1_read_data and rs2_read_data SHALL read 0 for every index, and bypass SHALL be suppressed.
REQ-030 The first write SHALL take effect on the first rising edge after rst deasserts.
REQ-031 Reset asserted mid-operation SHALL discard any write pending on that edge.

Structure
REQ-032 The shared package SHALL hold XLEN=32, REG_COUNT=32, REG_INDEX_W=5, and the typedefs reg_index_t (5 bits) and xlen_t (32 bits); the ports SHALL use these typedefs.
REQ-033 The block SHALL be a single module with no sub-modules; the storage array and the PC register SHALL both be inferred in this module.

Verification
REQ-034 Assert rst, release, then read all 32 indices on both ports -> every read returns 0, and pc_read_data=RESET_PC.
REQ-035 Write x5=32'hDEAD_BEEF, then on the next cycle read rs1=5 and rs2=5 -> both return 32'hDEAD_BEEF.
REQ-036 Write x0=32'hFFFF_FFFF while reading rs1=0 in the same cycle -> rs1 returns 0 that cycle and all later cycles.
REQ-037 BYPASS=1: write x7=32'h1234_5678 while reading rs2=7 in the same cycle -> 32'h1234_5678 that cycle; BYPASS=0 -> old value (0) that cycle, new value the next cycle.
REQ-038 pc_write_enable=1 with pc_write_data=32'h0000_0004 for 3 cycles, then enable=0 -> pc_read_data steps to 4 and then holds 4.
REQ-039 Write x31=32'hA5A5_A5A5 and PC=32'h100, then assert rst between clock edges -> x31 reads 0 and PC=RESET_PC before the next edge.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared widths and types for the integer register file and program counter.
package register_file_pkg;

    localparam int XLEN        = 32;
    localparam int REG_COUNT   = 32;
    localparam int REG_INDEX_W = 5;

    typedef logic [REG_INDEX_W-1:0] reg_index_t;
    typedef logic [XLEN-1:0]        xlen_t;

endpackage

// File: rtl/register_file.sv
// Two-read/one-write integer register file (x0 hardwired to zero) plus the PC register.
// Reads are combinational, with optional same-cycle forwarding of the write-back value.
module register_file
    import register_file_pkg::*;
#(
    parameter xlen_t RESET_PC = 32'h0000_0000,
    parameter bit    BYPASS   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  reg_index_t rs1_read_index,
    input  reg_index_t rs2_read_index,
    output xlen_t      rs1_read_data,
    output xlen_t      rs2_read_data,
    input  reg_index_t rd_write_index,
    input  xlen_t      rd_write_data,
    input  logic       rd_write_enable,
    input  xlen_t      pc_write_data,
    input  logic       pc_write_enable,
    output xlen_t      pc_read_data
);

    // x0 has no storage, so the array starts at index 1.
    xlen_t regs [1:REG_COUNT-1];
    xlen_t pc_q;
    logic  write_hit;

    assign write_hit = rd_write_enable && (rd_write_index != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[rd_write_index] <= rd_write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (pc_write_enable) begin
            pc_q <= pc_write_data;
        end
    end

    // Reset forces zero on both ports and also blocks forwarding of a pending write.
    always_comb begin
        rs1_read_data = '0;
        if (!rst && (rs1_read_index != '0)) begin
            if (BYPASS && write_hit && (rs1_read_index == rd_write_index)) begin
                rs1_read_data = rd_write_data;
            end else begin
                rs1_read_data = regs[rs1_read_index];
            end
        end
    end

    always_comb begin
        rs2_read_data = '0;
        if (!rst && (rs2_read_index != '0)) begin
            if (BYPASS && write_hit && (rs2_read_index == rd_write_index)) begin
                rs2_read_data = rd_write_data;
            end else begin
                rs2_read_data = regs[rs2_read_index];
            end
        end
    end

    assign pc_read_data = pc_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: forwarding and non-forwarding copies driven in lockstep,
// a directed vector table, a mid-cycle reset sequence and a randomized model-checked run.
module tb_register_file;
    import register_file_pkg::*;

    localparam xlen_t RST_PC  = 32'h0000_0200;
    localparam int    N_VECS  = 14;
    localparam int    N_RAND  = 400;

    logic       clk = 1'b0;
    logic       rst;
    reg_index_t rs1_idx, rs2_idx, wr_idx;
    xlen_t      wr_data, pc_data;
    logic       wr_en, pc_en;
    xlen_t      bp_rs1, bp_rs2, bp_pc;
    xlen_t      nb_rs1, nb_rs2, nb_pc;

    // clock / reset
    always #5 clk = ~clk;

    register_file #(.RESET_PC(RST_PC), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .rst(rst),
        .rs1_read_index(rs1_idx), .rs2_read_index(rs2_idx),
        .rs1_read_data(bp_rs1), .rs2_read_data(bp_rs2),
        .rd_write_index(wr_idx), .rd_write_data(wr_data), .rd_write_enable(wr_en),
        .pc_write_data(pc_data), .pc_write_enable(pc_en), .pc_read_data(bp_pc)
    );

    register_file #(.RESET_PC(RST_PC), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .rs1_read_index(rs1_idx), .rs2_read_index(rs2_idx),
        .rs1_read_data(nb_rs1), .rs2_read_data(nb_rs2),
        .rd_write_index(wr_idx), .rd_write_data(wr_data), .rd_write_enable(wr_en),
        .pc_write_data(pc_data), .pc_write_enable(pc_en), .pc_read_data(nb_pc)
    );

    typedef struct {
        reg_index_t rs1;
        reg_index_t rs2;
        logic       we;
        reg_index_t widx;
        xlen_t      wdata;
        logic       pe;
        xlen_t      pdata;
        xlen_t      e_rs1;
        xlen_t      e_rs2;
        xlen_t      n_rs1;
        xlen_t      n_rs2;
        xlen_t      e_pc;
    } vec_t;

    vec_t        vecs [N_VECS];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    // reference model of the architectural state
    xlen_t m_regs [REG_COUNT];
    xlen_t m_pc;

    function automatic xlen_t m_read(input reg_index_t idx, input bit fwd);
        if (rst || idx == '0) return '0;
        if (fwd && wr_en && wr_idx != '0 && wr_idx == idx) return wr_data;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < REG_COUNT; i++) m_regs[i] = '0;
        m_pc = RST_PC;
    endtask

    task automatic model_commit();
        if (!rst) begin
            if (wr_en && wr_idx != '0) m_regs[wr_idx] = wr_data;
            if (pc_en) m_pc = pc_data;
        end
    endtask

    // driver
    task automatic drive(input logic r, input reg_index_t r1, input reg_index_t r2,
                         input logic we, input reg_index_t wi, input xlen_t wd,
                         input logic pe, input xlen_t pd);
        @(negedge clk);
        rst     = r;
        rs1_idx = r1;
        rs2_idx = r2;
        wr_en   = we;
        wr_idx  = wi;
        wr_data = wd;
        pc_en   = pe;
        pc_data = pd;
        if (r) model_reset();
    endtask

    // scoreboard
    task automatic push6(input xlen_t a, input xlen_t b, input xlen_t c,
                         input xlen_t d, input xlen_t e, input xlen_t f);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        exp_q.push_back(d); exp_q.push_back(e); exp_q.push_back(f);
    endtask

    task automatic push_model();
        push6(m_read(rs1_idx, 1'b1), m_read(rs2_idx, 1'b1),
              m_read(rs1_idx, 1'b0), m_read(rs2_idx, 1'b0), m_pc, m_pc);
    endtask

    task automatic chk(input string tag, input string name, input xlen_t act);
        xlen_t exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.%s scoreboard empty, got %h", tag, name, act);
            return;
        end
        exp = exp_q.pop_front();
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h (t=%0t)", tag, name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs(input string tag);
        chk(tag, "bp_rs1", bp_rs1);
        chk(tag, "bp_rs2", bp_rs2);
        chk(tag, "nb_rs1", nb_rs1);
        chk(tag, "nb_rs2", nb_rs2);
        chk(tag, "bp_pc",  bp_pc);
        chk(tag, "nb_pc",  nb_pc);
    endtask

    task automatic model_cycle(input string tag);
        push_model();
        #2;
        compare_outputs(tag);
        model_commit();
    endtask

    initial begin
        // rs1 rs2 we widx wdata pe pdata | bp_rs1 bp_rs2 nb_rs1 nb_rs2 pc
        vecs[0]  = '{5'd1,  5'd2,  1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h200};
        vecs[1]  = '{5'd5,  5'd5,  1'b0, 5'd0,  32'h0, 1'b0, 32'h0,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h200};
        vecs[2]  = '{5'd0,  5'd5,  1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 32'h0,
                     32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h200};
        vecs[3]  = '{5'd0,  5'd0,  1'b0, 5'd0,  32'h0, 1'b0, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h200};
        vecs[4]  = '{5'd5,  5'd7,  1'b1, 5'd7,  32'h1234_5678, 1'b0, 32'h0,
                     32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 32'h200};
        vecs[5]  = '{5'd7,  5'd7,  1'b0, 5'd7,  32'hFFFF_0000, 1'b0, 32'h0,
                     32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h200};
        vecs[6]  = '{5'd7,  5'd5,  1'b1, 5'd5,  32'h0000_0011, 1'b1, 32'h4,
                     32'h1234_5678, 32'h11, 32'h1234_5678, 32'hDEAD_BEEF, 32'h200};
        vecs[7]  = '{5'd5,  5'd7,  1'b0, 5'd0,  32'h0, 1'b1, 32'h4,
                     32'h11, 32'h1234_5678, 32'h11, 32'h1234_5678, 32'h4};
        vecs[8]  = '{5'd5,  5'd7,  1'b0, 5'd0,  32'h0, 1'b1, 32'h4,
                     32'h11, 32'h1234_5678, 32'h11, 32'h1234_5678, 32'h4};
        vecs[9]  = '{5'd0,  5'd5,  1'b0, 5'd0,  32'h0, 1'b0, 32'hFFFF_FFFC,
                     32'h0, 32'h11, 32'h0, 32'h11, 32'h4};
        vecs[10] = '{5'd31, 5'd31, 1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 32'h100,
                     32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h4};
        vecs[11] = '{5'd31, 5'd0,  1'b0, 5'd0,  32'h0, 1'b0, 32'h0,
                     32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'h100};
        vecs[12] = '{5'd1,  5'd31, 1'b0, 5'd0,  32'h0, 1'b1, 32'h3,
                     32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h100};
        vecs[13] = '{5'd1,  5'd31, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0,
                     32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h3};

        rst = 1'b1; rs1_idx = '0; rs2_idx = '0; wr_en = 1'b0; wr_idx = '0;
        wr_data = '0; pc_en = 1'b0; pc_data = '0;
        model_reset();

        // held in reset: writes ignored and forwarding suppressed
        drive(1'b1, 5'd9, 5'd31, 1'b1, 5'd9, 32'h7777_0009, 1'b1, 32'h44);
        model_cycle("in_reset");
        drive(1'b1, 5'd31, 5'd9, 1'b1, 5'd31, 32'h7777_001F, 1'b0, 32'h0);
        model_cycle("in_reset");

        // every index on both ports reads zero after reset
        for (int i = 0; i < REG_COUNT; i++) begin
            drive(1'b0, reg_index_t'(i), reg_index_t'(REG_COUNT - 1 - i), 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
            model_cycle("post_reset");
        end

        for (int i = 0; i < N_VECS; i++) begin
            drive(1'b0, vecs[i].rs1, vecs[i].rs2, vecs[i].we, vecs[i].widx,
                  vecs[i].wdata, vecs[i].pe, vecs[i].pdata);
            push6(vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].n_rs1, vecs[i].n_rs2,
                  vecs[i].e_pc, vecs[i].e_pc);
            #2;
            compare_outputs($sformatf("vec%0d", i));
            model_commit();
        end

        // reset arrives between edges while a register and PC write are pending
        drive(1'b0, 5'd9, 5'd31, 1'b1, 5'd9, 32'hCAFE_0009, 1'b1, 32'h40);
        push6(32'hCAFE_0009, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h3, 32'h3);
        #2;
        compare_outputs("mid_pre");
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        push6(32'h0, 32'h0, 32'h0, 32'h0, RST_PC, RST_PC);
        compare_outputs("mid_async");

        drive(1'b1, 5'd9, 5'd31, 1'b1, 5'd9, 32'hCAFE_1111, 1'b1, 32'h80);
        model_cycle("mid_hold");
        drive(1'b0, 5'd9, 5'd31, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 32'h0);
        model_cycle("first_write");
        drive(1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        model_cycle("first_read");

        // randomized traffic concentrated on a few registers to provoke forwarding hits
        for (int n = 0; n < N_RAND; n++) begin
            drive(($urandom_range(0, 39) == 0),
                  reg_index_t'($urandom_range(0, 7)),
                  reg_index_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  reg_index_t'($urandom_range(0, 7)),
                  $urandom(),
                  ($urandom_range(0, 3) == 0),
                  $urandom());
            model_cycle("rand");
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover scoreboard entries got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
